// File: rtl/rolling_buffer_scan_ctrl.sv
// Frame-scan sequencer for the 9-row rolling line buffer.
// Reads a stored frame in raster order and tags each sample with its column and row.
// A short idle gap follows every row so the buffer can see the row boundary.
// After the last row, the first FLUSH_ROWS rows are streamed again so the buffer's
// delayed output reaches the bottom of the frame.
module rolling_buffer_scan_ctrl #(
  parameter int H_PIXELS     = 24,
  parameter int V_LINES      = 32,
  parameter int READ_LATENCY = 2,
  parameter int LINE_GAP     = 2,
  parameter int FLUSH_ROWS   = 5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  output logic [9:0]         frame_addr_out,
  input  logic signed [20:0] frame_data_in,
  output logic signed [20:0] pixel_data_out,
  output logic [4:0]         hcount_out,
  output logic [4:0]         vcount_out,
  output logic               data_valid_out,
  output logic               busy_out,
  output logic               primed_out,
  output logic               frame_done_out
);

  localparam int TOTAL_ROWS = V_LINES + FLUSH_ROWS;
  localparam int RW         = $clog2(TOTAL_ROWS + 1);
  localparam int WAIT_MAX   = (LINE_GAP > READ_LATENCY + 1) ? LINE_GAP : READ_LATENCY + 1;
  localparam int CW         = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    GAP,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [4:0]      h_cnt;
  logic [4:0]      vrow;
  logic [RW-1:0]   row_cnt;
  logic [RW-1:0]   row_next;
  logic [CW-1:0]   wait_cnt;
  logic [3:0]      row_end_cnt;
  logic            accept;

  logic [4:0]      tag_h     [READ_LATENCY];
  logic [4:0]      tag_v     [READ_LATENCY];
  logic            tag_valid [READ_LATENCY];

  // A start is only taken when fully idle, including the frame_done cycle, which
  // still shows busy; this keeps a late start from overlapping the finishing frame.
  assign accept   = (state == IDLE) && start_in && !busy_out;
  assign row_next = row_cnt + RW'(1);

  // Main sequencer: walks rows and columns, issues read addresses, and owns busy/done.
  // The address register always holds the address being issued in the current cycle,
  // so it is loaded one step ahead; row changes step by one row (or wrap to row 0
  // for the flush rows) which avoids a multiplier.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      h_cnt          <= '0;
      vrow           <= '0;
      row_cnt        <= '0;
      wait_cnt       <= '0;
      frame_addr_out <= '0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= (state == DONE);
      if (frame_done_out) begin
        busy_out <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= SCAN;
            h_cnt          <= '0;
            vrow           <= '0;
            row_cnt        <= '0;
            frame_addr_out <= '0;
            busy_out       <= 1'b1;
          end
        end
        SCAN: begin
          if (h_cnt == 5'(H_PIXELS - 1)) begin
            h_cnt    <= '0;
            wait_cnt <= '0;
            state    <= GAP;
          end else begin
            h_cnt          <= h_cnt + 5'd1;
            frame_addr_out <= frame_addr_out + 10'd1;
          end
        end
        GAP: begin
          if (wait_cnt == CW'(LINE_GAP - 1)) begin
            row_cnt  <= row_next;
            wait_cnt <= '0;
            if (row_next < RW'(TOTAL_ROWS)) begin
              state <= SCAN;
              if (vrow == 5'(V_LINES - 1)) begin
                vrow           <= '0;
                frame_addr_out <= '0;
              end else begin
                vrow           <= vrow + 5'd1;
                frame_addr_out <= frame_addr_out + 10'd1;
              end
            end else begin
              state <= DRAIN;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (wait_cnt == CW'(READ_LATENCY)) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag delay line: carries column/row/valid alongside the memory read latency.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_h[i]     <= '0;
        tag_v[i]     <= '0;
        tag_valid[i] <= 1'b0;
      end
    end else begin
      tag_h[0]     <= h_cnt;
      tag_v[0]     <= vrow;
      tag_valid[0] <= (state == SCAN);
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_h[i]     <= tag_h[i-1];
        tag_v[i]     <= tag_v[i-1];
        tag_valid[i] <= tag_valid[i-1];
      end
    end
  end

  // Output register: captures the returned sample with its tag; holds values on idle cycles.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      data_valid_out <= 1'b0;
    end else if (tag_valid[READ_LATENCY-1]) begin
      pixel_data_out <= frame_data_in;
      hcount_out     <= tag_h[READ_LATENCY-1];
      vcount_out     <= tag_v[READ_LATENCY-1];
      data_valid_out <= 1'b1;
    end else begin
      data_valid_out <= 1'b0;
    end
  end

  // Primed tracker: counts delivered row ends (saturating at 9) since the last start.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      row_end_cnt <= '0;
      primed_out  <= 1'b0;
    end else if (accept) begin
      row_end_cnt <= '0;
      primed_out  <= 1'b0;
    end else if (data_valid_out && (hcount_out == 5'(H_PIXELS - 1)) && (row_end_cnt != 4'd9)) begin
      row_end_cnt <= row_end_cnt + 4'd1;
      if (row_end_cnt == 4'd8) begin
        primed_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rolling_buffer_scan_ctrl.sv
// Directed testbench for rolling_buffer_scan_ctrl.
// Instance A uses default parameters; instance B uses READ_LATENCY=1, LINE_GAP=1,
// FLUSH_ROWS=0. Both read a shared frame memory through their own latency pipelines.
module tb_rolling_buffer_scan_ctrl;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic               rst_in;
  logic               start_a, start_b;
  logic [9:0]         addr_a, addr_b;
  logic signed [20:0] data_a, data_b, pix_a, pix_b;
  logic [4:0]         h_a, v_a, h_b, v_b;
  logic               dv_a, busy_a, primed_a, done_a;
  logic               dv_b, busy_b, primed_b, done_b;

  logic signed [20:0] mem [0:767];
  logic signed [20:0] rd_a1, rd_a2, rd_b1;

  int vectors     = 0;
  int miscompares = 0;

  rolling_buffer_scan_ctrl dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_a),
    .frame_addr_out(addr_a), .frame_data_in(data_a),
    .pixel_data_out(pix_a), .hcount_out(h_a), .vcount_out(v_a),
    .data_valid_out(dv_a), .busy_out(busy_a), .primed_out(primed_a),
    .frame_done_out(done_a)
  );

  rolling_buffer_scan_ctrl #(
    .H_PIXELS(24), .V_LINES(32), .READ_LATENCY(1), .LINE_GAP(1), .FLUSH_ROWS(0)
  ) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b),
    .frame_addr_out(addr_b), .frame_data_in(data_b),
    .pixel_data_out(pix_b), .hcount_out(h_b), .vcount_out(v_b),
    .data_valid_out(dv_b), .busy_out(busy_b), .primed_out(primed_b),
    .frame_done_out(done_b)
  );

  // Frame memory read pipelines: two cycles for A, one cycle for B.
  always @(posedge clk_in) begin
    rd_a1 <= mem[addr_a];
    rd_a2 <= rd_a1;
    rd_b1 <= mem[addr_b];
  end
  assign data_a = rd_a2;
  assign data_b = rd_b1;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({addr_a, pix_a, h_a, v_a, dv_a, busy_a, primed_a, done_a} !== 45'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_a: got addr=%0d pix=%0d h=%0d v=%0d dv=%b busy=%b primed=%b done=%b, expected all 0",
               addr_a, pix_a, h_a, v_a, dv_a, busy_a, primed_a, done_a);
    end
    vectors++;
    if ({addr_b, pix_b, h_b, v_b, dv_b, busy_b, primed_b, done_b} !== 45'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_b: got addr=%0d pix=%0d h=%0d v=%0d dv=%b busy=%b primed=%b done=%b, expected all 0",
               addr_b, pix_b, h_b, v_b, dv_b, busy_b, primed_b, done_b);
    end
    rst_in = 1'b1;
    repeat (5) tick();
    vectors++;
    if ({dv_a, busy_a, done_a, addr_a} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_quiet: got dv=%b busy=%b done=%b addr=%0d, expected 0 0 0 0",
               dv_a, busy_a, done_a, addr_a);
    end
  endtask

  // Full default frame with identity memory contents.
  task automatic test_stream();
    int k, n, eh, row, ev, ep, done_k, busy_bad, primed_bad;
    n = 0; done_k = -1; busy_bad = 0; primed_bad = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = 1;
    while (k <= 1100) begin
      if (k == 3) begin
        vectors++;
        if (dv_a !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL early_valid: got dv=%b at start+3, expected 0", dv_a);
        end
      end
      if (k == 4) begin
        vectors++;
        if (dv_a !== 1'b1 || pix_a !== 21'sd0 || h_a !== 5'd0 || v_a !== 5'd0) begin
          miscompares++;
          $display("[TB] FAIL first_valid: got dv=%b pix=%0d h=%0d v=%0d, expected 1 0 0 0", dv_a, pix_a, h_a, v_a);
        end
      end
      if (dv_a === 1'b1) begin
        eh  = n % 24;
        row = n / 24;
        ev  = (row < 32) ? row : row - 32;
        ep  = ev * 24 + eh;
        vectors++;
        if (h_a !== eh[4:0] || v_a !== ev[4:0] || pix_a !== ep[20:0]) begin
          miscompares++;
          $display("[TB] FAIL stream_sample n=%0d: got h=%0d v=%0d pix=%0d, expected h=%0d v=%0d pix=%0d",
                   n, h_a, v_a, pix_a, eh, ev, ep);
        end
        if (n == 767) begin
          vectors++;
          if (pix_a !== 21'sd767) begin
            miscompares++;
            $display("[TB] FAIL last_pixel: got %0d, expected 767", pix_a);
          end
        end
        n++;
      end
      if (k == 834 || k == 835) begin
        vectors++;
        if (dv_a !== 1'b0 || h_a !== 5'd23 || v_a !== 5'd31 || pix_a !== 21'sd767) begin
          miscompares++;
          $display("[TB] FAIL row_gap_hold k=%0d: got dv=%b h=%0d v=%0d pix=%0d, expected 0 23 31 767",
                   k, dv_a, h_a, v_a, pix_a);
        end
      end
      if (k == 836) begin
        vectors++;
        if (dv_a !== 1'b1 || h_a !== 5'd0 || v_a !== 5'd0 || pix_a !== 21'sd0) begin
          miscompares++;
          $display("[TB] FAIL flush_start: got dv=%b h=%0d v=%0d pix=%0d, expected 1 0 0 0", dv_a, h_a, v_a, pix_a);
        end
      end
      if (k == 235) begin
        vectors++;
        if (primed_a !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL primed_early: got %b, expected 0", primed_a);
        end
      end
      if (k == 236) begin
        vectors++;
        if (primed_a !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL primed_rise: got %b, expected 1", primed_a);
        end
      end
      if (k > 236 && primed_a !== 1'b1) primed_bad++;
      if (busy_a !== 1'b1) busy_bad++;
      if (done_a === 1'b1) begin
        done_k = k;
        break;
      end
      tick();
      k++;
    end
    vectors++;
    if (done_k != 967) begin
      miscompares++;
      $display("[TB] FAIL frame_done_cycle: got %0d, expected 967", done_k);
    end
    vectors++;
    if (n != 888) begin
      miscompares++;
      $display("[TB] FAIL valid_count: got %0d, expected 888", n);
    end
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL busy_during_frame: got %0d low cycles, expected 0", busy_bad);
    end
    vectors++;
    if (primed_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL primed_stays: got %0d low cycles, expected 0", primed_bad);
    end
    tick();
    vectors++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || primed_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL after_frame: got busy=%b done=%b primed=%b, expected 0 0 1", busy_a, done_a, primed_a);
    end
  endtask

  // Negative sample keeps its sign; start pulses during SCAN, DONE and the done cycle are ignored.
  task automatic test_sign_and_ignore();
    int k, done_k, extra_busy, extra_valid;
    done_k = -1; extra_busy = 0; extra_valid = 0;
    mem[5] = -21'sd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = 1;
    while (k <= 1100) begin
      start_a = (k == 50 || k == 966 || k == 967);
      if (k == 1) begin
        vectors++;
        if (primed_a !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL primed_clear_on_start: got %b, expected 0", primed_a);
        end
      end
      if (k == 8) begin
        vectors++;
        if (dv_a !== 1'b1 || h_a !== 5'd4 || pix_a !== 21'sd4) begin
          miscompares++;
          $display("[TB] FAIL neighbour_pixel: got dv=%b h=%0d pix=%0d, expected 1 4 4", dv_a, h_a, pix_a);
        end
      end
      if (k == 9) begin
        vectors++;
        if (dv_a !== 1'b1 || h_a !== 5'd5 || v_a !== 5'd0 || pix_a !== 21'h1FFFFF) begin
          miscompares++;
          $display("[TB] FAIL sign_preserved: got dv=%b h=%0d v=%0d pix=%h, expected 1 5 0 1fffff",
                   dv_a, h_a, v_a, pix_a);
        end
      end
      if (done_a === 1'b1) begin
        done_k = k;
        break;
      end
      tick();
      k++;
    end
    tick();
    start_a = 1'b0;
    vectors++;
    if (done_k != 967) begin
      miscompares++;
      $display("[TB] FAIL ignored_start_done: got %0d, expected 967", done_k);
    end
    for (int i = 0; i < 30; i++) begin
      if (busy_a === 1'b1) extra_busy++;
      if (dv_a === 1'b1) extra_valid++;
      tick();
    end
    vectors++;
    if (extra_busy != 0 || extra_valid != 0) begin
      miscompares++;
      $display("[TB] FAIL no_second_frame: got busy=%0d valid=%0d cycles, expected 0 0", extra_busy, extra_valid);
    end
    vectors++;
    if (primed_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL primed_held_idle: got %b, expected 1", primed_a);
    end
    mem[5] = 21'sd5;
  endtask

  // Reset asserted while issuing row 3 column 10, then a clean restart.
  task automatic test_reset_mid();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (88) tick();
    vectors++;
    if (addr_a !== 10'd82 || dv_a !== 1'b1 || h_a !== 5'd7 || v_a !== 5'd3 || pix_a !== 21'sd79) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_state: got addr=%0d dv=%b h=%0d v=%0d pix=%0d, expected 82 1 7 3 79",
               addr_a, dv_a, h_a, v_a, pix_a);
    end
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    vectors++;
    if ({addr_a, pix_a, h_a, v_a, dv_a, busy_a, primed_a, done_a} !== 45'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got addr=%0d pix=%0d h=%0d v=%0d dv=%b busy=%b primed=%b done=%b, expected all 0",
               addr_a, pix_a, h_a, v_a, dv_a, busy_a, primed_a, done_a);
    end
    tick();
    tick();
    vectors++;
    if (dv_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: got dv=%b busy=%b, expected 0 0", dv_a, busy_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    vectors++;
    if (addr_a !== 10'd0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_addr0: got addr=%0d busy=%b, expected 0 1", addr_a, busy_a);
    end
    tick();
    vectors++;
    if (addr_a !== 10'd1) begin
      miscompares++;
      $display("[TB] FAIL restart_addr1: got addr=%0d, expected 1", addr_a);
    end
    tick();
    tick();
    vectors++;
    if (dv_a !== 1'b1 || pix_a !== 21'sd0 || h_a !== 5'd0 || v_a !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_first_valid: got dv=%b pix=%0d h=%0d v=%0d, expected 1 0 0 0", dv_a, pix_a, h_a, v_a);
    end
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  // Short configuration: one-cycle memory, one gap cycle, no flush rows.
  task automatic test_short();
    int k, n, eh, ev, done_k;
    n = 0; done_k = -1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    k = 1;
    while (k <= 1000) begin
      if (k == 2) begin
        vectors++;
        if (dv_b !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL short_early_valid: got dv=%b, expected 0", dv_b);
        end
      end
      if (k == 3) begin
        vectors++;
        if (dv_b !== 1'b1 || pix_b !== 21'sd0 || h_b !== 5'd0 || v_b !== 5'd0) begin
          miscompares++;
          $display("[TB] FAIL short_first_valid: got dv=%b pix=%0d h=%0d v=%0d, expected 1 0 0 0", dv_b, pix_b, h_b, v_b);
        end
      end
      if (dv_b === 1'b1) begin
        eh = n % 24;
        ev = n / 24;
        vectors++;
        if (h_b !== eh[4:0] || v_b !== ev[4:0] || pix_b !== n[20:0]) begin
          miscompares++;
          $display("[TB] FAIL short_sample n=%0d: got h=%0d v=%0d pix=%0d, expected h=%0d v=%0d pix=%0d",
                   n, h_b, v_b, pix_b, eh, ev, n);
        end
        n++;
      end
      if (k == 226 || k == 227) begin
        vectors++;
        if (primed_b !== (k == 227)) begin
          miscompares++;
          $display("[TB] FAIL short_primed k=%0d: got %b, expected %b", k, primed_b, (k == 227));
        end
      end
      if (done_b === 1'b1) begin
        done_k = k;
        break;
      end
      tick();
      k++;
    end
    vectors++;
    if (done_k != 804) begin
      miscompares++;
      $display("[TB] FAIL short_done_cycle: got %0d, expected 804", done_k);
    end
    vectors++;
    if (n != 768) begin
      miscompares++;
      $display("[TB] FAIL short_valid_count: got %0d, expected 768", n);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 768; i++) mem[i] = 21'(i);
    test_reset();
    test_stream();
    test_sign_and_ignore();
    test_reset_mid();
    test_short();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
